dmem_bytelane: RTL and testbench
================================

# dmem_bytelane

Byte-addressed, parametrised data memory for the single-cycle MIPS datapath. It replaces the fixed 1024-word array with three additions:
- byte, halfword and word stores and loads (LB/LBU/LH/LHU/LW/SB/SH/SW);
- misalignment detection;
- a synthesizable reset-time clear sweep, driven by a counter FSM with a busy flag, in place of a one-cycle array clear.

Reads stay combinational so the single-cycle core timing is unchanged.

## Interface
- ADDR_W, 10, word-address bits; depth = 2^ADDR_W words of 32 bits
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents undefined and no sweep

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (low = in reset)
- addr  input  ADDR_W+2  byte address; word index = addr[ADDR_W+1:2], lane = addr[1:0]
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- wr  input  1  store request
- rd  input  1  load request; qualifies misalign only, rdata is always driven
- size  input  2  00 byte, 01 half, 10 word, 11 illegal
- uns  input  1  load zero-extends when 1, sign-extends when 0 (ignored for word)
- rdata  output  32  load result, combinational
- busy  output  1  clear sweep in progress
- misalign  output  1  combinational access-fault flag
- fault_sticky  output  1  registered; set by any faulting access, cleared only by reset

## Operation
- FSM states: CLEAR, IDLE.
  - While rst is low: state = (CLEAR_ON_RESET ? CLEAR : IDLE), ptr = 0, fault_sticky = 0.
  - busy = (state == CLEAR), so busy is 1 in reset when CLEAR_ON_RESET = 1, else 0.
- CLEAR: each edge writes mem[ptr] = 0 and increments ptr. On the edge that clears word 2^ADDR_W−1, state becomes IDLE and ptr wraps to 0.
- Array contents are never touched by the asynchronous reset itself; only the sweep clears them.
- Fault condition: (rd | wr) & (size == 11 | (size == 01 & addr[0]) | (size == 10 & addr[1:0] != 0)).
  - misalign = fault condition, including while busy.
  - fault_sticky is set at the next edge after any cycle where the fault condition holds.
- Store in IDLE with wr = 1 and no fault:
  - byte: write wdata[7:0] into lane addr[1:0].
  - half: write wdata[15:0] into bytes {addr[1],1}:{addr[1],0}.
  - word: write all 4 bytes.
  - Unselected bytes keep their value.
- Suppressed stores: misaligned stores, and any store while busy. Either leaves the array unchanged.
- Load: let W = mem[word index].
  - byte: W[8·lane+7 : 8·lane], then extended.
  - half: W[16·addr[1]+15 : 16·addr[1]], then extended.
  - word: W unchanged.
- rdata = 0 while busy, and 0 for size = 11. A misaligned half or word load returns the extraction using the truncated lane bits (don't-care for the core; the trap uses misalign).
- Lane mapping is little-endian: lane 0 = bits [7:0].

## Timing
- Load latency is 0 cycles: rdata follows addr, size, uns and the array combinationally.
- Store takes effect at the rising edge. A load of the same address in the same cycle returns the pre-store value; the next cycle returns the new value.
- Sweep length: busy deasserts after exactly 2^ADDR_W edges following rst release (1024 for the default).
- Reset asserted mid-sweep: busy stays 1 and ptr returns to 0. The sweep restarts from word 0 on release.
- Store presented on the same edge that ends the sweep: suppressed, because busy was 1 during that cycle.
- CLEAR_ON_RESET = 0: the first edge after release accepts stores.

## Test plan
- Reset release, CLEAR_ON_RESET = 1, ADDR_W = 4 -> busy = 1 for 16 edges then 0. Every word reads 0x00000000. wr = 1 at 0x0 during the sweep leaves 0.
- Store word 0x8899AABB at addr 0x10, then byte loads at 0x10..0x13 with uns = 0 -> 0xFFFFFFBB, 0xFFFFFFAA, 0xFFFFFF99, 0xFFFFFF88. Same loads with uns = 1 -> 0xBB, 0xAA, 0x99, 0x88.
- Over word 0x8899AABB: SB 0x11 with wdata 0x000000CC -> word 0x8899CCBB. SH 0x12 with wdata 0x00001234 -> 0x1234CCBB. LH 0x12, uns = 0 -> 0x00001234.
- SW to 0x21 with wdata 0xDEADBEEF -> misalign = 1 in that cycle, word 0x20 unchanged, fault_sticky = 1 from the next cycle until reset. Also LH at 0x23 and size = 11 with rd = 1 -> misalign = 1.
- Reset pulsed at sweep edge 7 -> busy stays high, and a full 2^ADDR_W more edges are counted after release before busy = 0.
- Same-cycle SW 0x11223344 and LW at 0x40 -> old value in that cycle, 0x11223344 in the next cycle.

Source files
------------

// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - byte-lane data memory with LB/LH/LW loads, SB/SH/SW stores,
// misalignment flagging and a counter-driven clear sweep after reset.
module dmem_bytelane #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              wr,
  input  logic              rd,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              misalign,
  output logic              fault_sticky
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
  localparam int     DEPTH       = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              fault_q, fault_d;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              fault_cond;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  logic [31:0]       rword;
  logic [31:0]       rshift;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  assign word_idx = addr[ADDR_W+1:2];
  assign lane     = addr[1:0];

  always_comb begin
    fault_cond = 1'b0;
    if (rd | wr) begin
      case (size)
        2'b01:   fault_cond = addr[0];
        2'b10:   fault_cond = (lane != 2'b00);
        2'b11:   fault_cond = 1'b1;
        default: fault_cond = 1'b0;
      endcase
    end
  end

  assign busy         = (state_q == S_CLEAR);
  assign misalign     = fault_cond;
  assign fault_sticky = fault_q;

  // Sweep owns the write port while busy; core stores are dropped.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fault_d   = fault_q | fault_cond;
    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = ptr_q;
        mem_be    = 4'hF;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (wr && !fault_cond) begin
          mem_we = 1'b1;
          case (size)
            2'b00: begin
              mem_be    = 4'b0001 << lane;
              mem_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
              mem_be    = addr[1] ? 4'b1100 : 4'b0011;
              mem_wdata = {2{wdata[15:0]}};
            end
            default: begin
              mem_be    = 4'hF;
              mem_wdata = wdata;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fault_q <= fault_d;
    end
  end

  // Array has no reset; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rword  = mem[word_idx];
  assign rshift = rword >> {lane, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rdata = 32'h0;
    if (!busy) begin
      case (size)
        2'b00:   rdata = uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
        2'b01:   rdata = uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        2'b10:   rdata = rword;
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb/tb_dmem_bytelane.sv - self-checking bench for dmem_bytelane against a byte-array model.
module tb_dmem_bytelane;

  localparam int ADDR_W = 4;
  localparam int NBYTES = 4 * (2 ** ADDR_W);

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic              wr;
  logic              rd;
  logic [1:0]        size;
  logic              uns;
  logic [31:0]       rdata;
  logic              busy;
  logic              misalign;
  logic              fault_sticky;

  int errors = 0;
  int checks = 0;

  logic [7:0] mm [NBYTES];

  dmem_bytelane #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
    .size(size), .uns(uns), .rdata(rdata), .busy(busy), .misalign(misalign),
    .fault_sticky(fault_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_fault(int a, logic [1:0] sz, logic r, logic w);
    if (!(r | w)) return 1'b0;
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(int a, logic [1:0] sz, logic u);
    int base;
    int hb;
    logic [15:0] h;
    base = a - (a % 4);
    hb   = base + (((a % 4) >= 2) ? 2 : 0);
    case (sz)
      2'b00: return u ? 32'(mm[a]) : 32'($signed(mm[a]));
      2'b01: begin
        h = {mm[hb+1], mm[hb]};
        return u ? 32'(h) : 32'($signed(h));
      end
      2'b10: return {mm[base+3], mm[base+2], mm[base+1], mm[base]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_store(int a, logic [1:0] sz, logic [31:0] d);
    int base;
    int hb;
    base = a - (a % 4);
    hb   = base + (((a % 4) >= 2) ? 2 : 0);
    case (sz)
      2'b00: mm[a] = d[7:0];
      2'b01: begin mm[hb] = d[7:0]; mm[hb+1] = d[15:8]; end
      2'b10: for (int i = 0; i < 4; i++) mm[base+i] = d[8*i +: 8];
      default: ;
    endcase
  endfunction

  task automatic idle_inputs();
    wr = 0; rd = 0; size = 2'b10; uns = 0; addr = '0; wdata = '0;
  endtask

  task automatic do_store(int a, logic [1:0] sz, logic [31:0] d);
    addr = (ADDR_W+2)'(a); size = sz; wdata = d; wr = 1; rd = 0;
    tick();
    wr = 0;
    if (!m_fault(a, sz, 1'b0, 1'b1)) m_store(a % NBYTES, sz, d);
  endtask

  task automatic chk_load(string name, int a, logic [1:0] sz, logic u, logic [31:0] exp);
    addr = (ADDR_W+2)'(a); size = sz; uns = u; rd = 1; wr = 0;
    #1;
    checks++;
    if (rdata !== exp) begin
      errors++;
      $display("FAIL %s addr=%0h got=%08h exp=%08h", name, a, rdata, exp);
    end
    rd = 0;
  endtask

  task automatic check_all_zero(string name);
    for (int w = 0; w < NBYTES / 4; w++) begin
      addr = (ADDR_W+2)'(w * 4); size = 2'b10; rd = 1;
      #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL %s word=%0d got=%08h exp=00000000", name, w, rdata);
      end
    end
    rd = 0;
  endtask

  // Counts edges after release until busy drops; expects exactly the array depth.
  task automatic count_sweep(string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != NBYTES / 4) begin
      errors++;
      $display("FAIL %s sweep_edges got=%0d exp=%0d", name, n, NBYTES / 4);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #22;
    checks++;
    if (busy !== 1'b1 || fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b sticky=%b exp busy=1 sticky=0", busy, fault_sticky);
    end
    @(posedge clk); #1;
    rst = 1;
    // Store held through the whole sweep, including its final edge, must be dropped.
    addr = '0; size = 2'b10; wdata = 32'hFFFF_FFFF; wr = 1;
    #1;
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL sweep_start busy=%b rdata=%08h exp busy=1 rdata=0", busy, rdata);
    end
    count_sweep("sweep_len");
    wr = 0;
    for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
    check_all_zero("after_sweep");
  endtask

  task automatic test_byte_loads();
    logic [31:0] sx [4] = '{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88};
    logic [31:0] zx [4] = '{32'hBB, 32'hAA, 32'h99, 32'h88};
    do_store(32'h10, 2'b10, 32'h8899AABB);
    for (int i = 0; i < 4; i++) chk_load("lb", 32'h10 + i, 2'b00, 1'b0, sx[i]);
    for (int i = 0; i < 4; i++) chk_load("lbu", 32'h10 + i, 2'b00, 1'b1, zx[i]);
  endtask

  task automatic test_subword_store();
    do_store(32'h11, 2'b00, 32'h000000CC);
    chk_load("sb_word", 32'h10, 2'b10, 1'b0, 32'h8899CCBB);
    do_store(32'h12, 2'b01, 32'h00001234);
    chk_load("sh_word", 32'h10, 2'b10, 1'b0, 32'h1234CCBB);
    chk_load("lh", 32'h12, 2'b01, 1'b0, 32'h00001234);
  endtask

  task automatic test_misalign();
    addr = 6'h21; size = 2'b10; wdata = 32'hDEADBEEF; wr = 1; rd = 0;
    #1;
    checks++;
    if (misalign !== 1'b1 || fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sw_misalign misalign=%b sticky=%b exp 1/0", misalign, fault_sticky);
    end
    tick();
    wr = 0;
    checks++;
    if (fault_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set got=%b exp=1", fault_sticky);
    end
    chk_load("sw_suppressed", 32'h20, 2'b10, 1'b0, m_load(32'h20, 2'b10, 1'b0));
    addr = 6'h23; size = 2'b01; rd = 1;
    #1;
    checks++;
    if (misalign !== 1'b1) begin
      errors++;
      $display("FAIL lh_misalign got=%b exp=1", misalign);
    end
    addr = 6'h10; size = 2'b11;
    #1;
    checks++;
    if (misalign !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL size11 misalign=%b rdata=%08h exp 1/00000000", misalign, rdata);
    end
    rd = 0;
    tick();
  endtask

  task automatic test_same_cycle();
    logic [31:0] old;
    old = m_load(32'h40 % NBYTES, 2'b10, 1'b0);
    addr = 6'(32'h40); size = 2'b10; wdata = 32'h11223344; wr = 1; rd = 1;
    #1;
    checks++;
    if (rdata !== old) begin
      errors++;
      $display("FAIL same_cycle_old got=%08h exp=%08h", rdata, old);
    end
    tick();
    wr = 0;
    m_store(32'h40 % NBYTES, 2'b10, 32'h11223344);
    #1;
    checks++;
    if (rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL same_cycle_new got=%08h exp=11223344", rdata);
    end
    rd = 0;
  endtask

  task automatic test_random();
    int a;
    logic [1:0] sz;
    logic u, w, r;
    logic [31:0] d, exp_rd;
    bit exp_f;
    for (int it = 0; it < 300; it++) begin
      a = int'($urandom_range(0, NBYTES - 1));
      sz = 2'($urandom_range(0, 3));
      u = 1'($urandom); w = 1'($urandom); r = 1'($urandom);
      d = $urandom;
      addr = (ADDR_W+2)'(a); size = sz; uns = u; wr = w; rd = r; wdata = d;
      exp_rd = m_load(a, sz, u);
      exp_f  = m_fault(a, sz, r, w);
      #1;
      checks++;
      if (rdata !== exp_rd || misalign !== exp_f) begin
        errors++;
        $display("FAIL rand it=%0d a=%0h sz=%0d rdata=%08h exp=%08h mis=%b exp=%b",
                 it, a, sz, rdata, exp_rd, misalign, exp_f);
      end
      tick();
      if (w && !exp_f) m_store(a, sz, d);
    end
    idle_inputs();
    checks++;
    if (fault_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold got=%b exp=1", fault_sticky);
    end
  endtask

  task automatic test_reset_midsweep();
    idle_inputs();
    do_store(32'h08, 2'b10, 32'hCAFEF00D);
    rst = 0; #3; rst = 1;
    for (int i = 0; i < 7; i++) tick();
    rst = 0;
    #2;
    checks++;
    if (busy !== 1'b1 || fault_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_reset busy=%b sticky=%b exp 1/0", busy, fault_sticky);
    end
    tick();
    rst = 1;
    count_sweep("restart_len");
    for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
    check_all_zero("restart_clear");
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_subword_store();
    test_misalign();
    test_same_cycle();
    test_random();
    test_reset_midsweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
